// File: rtl/output_forward_if.sv
// output_forward_if: bus between the forward output neuron and its
// hidden-layer bank / sequencer.
//   en_i         : forward-pass enable (f_pass), level-sensitive
//   clr_i        : synchronous clear
//   idx_o        : index of the (hidden, weight) pair being read
//   hidden_val_i : 10-bit unsigned activation for idx_o
//   w_i          : 8-bit unsigned weight for idx_o
//   final_o      : registered forward result
//   f_end_o      : result of the current pass is valid
// Modports: master (sequencer / data source), slave (neuron).
interface output_forward_if #(
    parameter int N_HIDDEN = 4,
    parameter int OUT_W    = 23
);
    localparam int IDX_W = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;

    logic             en_i;
    logic             clr_i;
    logic [IDX_W-1:0] idx_o;
    logic [9:0]       hidden_val_i;
    logic [7:0]       w_i;
    logic [OUT_W-1:0] final_o;
    logic             f_end_o;

    modport master (
        output en_i, clr_i, hidden_val_i, w_i,
        input  idx_o, final_o, f_end_o
    );

    modport slave (
        input  en_i, clr_i, hidden_val_i, w_i,
        output idx_o, final_o, f_end_o
    );
endinterface

// File: rtl/output_forward.sv
// output_forward: forward-pass output neuron. Multiply-accumulates one
// (hidden, weight) pair per cycle over N_HIDDEN indices, then holds the
// result with f_end_o high until en_i drops.
// Ports: clk_i (clock), rst_i (async active-high reset),
//        bus (output_forward_if.slave: en/clr/idx/data/final/f_end).
// Config: define OUTPUT_FORWARD_SAT_EN to clamp the accumulator at
//         2^OUT_W-1 instead of wrapping modulo 2^OUT_W.
module output_forward #(
    parameter int N_HIDDEN = 4,
    parameter int OUT_W    = 23
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output_forward_if.slave    bus
);
    localparam int IDX_W = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_HIDDEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [OUT_W-1:0] r_acc;
    logic [OUT_W-1:0] r_final;
    logic             r_fend;

    logic [17:0]      w_prod;
    logic [OUT_W-1:0] w_sum;

    assign w_prod = 18'(bus.hidden_val_i) * 18'(bus.w_i);

`ifdef OUTPUT_FORWARD_SAT_EN
    // Clamp on carry-out. Once at the maximum, any nonzero product
    // carries again, so the clamp stays in place for the rest of the pass.
    logic [OUT_W:0] w_wide;
    assign w_wide = {1'b0, r_acc} + (OUT_W+1)'(w_prod);
    assign w_sum  = w_wide[OUT_W] ? '1 : w_wide[OUT_W-1:0];
`else
    assign w_sum = r_acc + OUT_W'(w_prod);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_acc   <= '0;
            r_final <= '0;
            r_fend  <= 1'b0;
        end else if (bus.clr_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_acc   <= '0;
            r_final <= '0;
            r_fend  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.en_i) begin
                        r_state <= S_ACCUM;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end
                end
                S_ACCUM: begin
                    if (!bus.en_i) begin
                        // Abort: partial sum dropped, old result kept.
                        r_state <= S_IDLE;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end else if (r_idx == LAST_IDX) begin
                        r_state <= S_DONE;
                        r_idx   <= '0;
                        r_acc   <= w_sum;
                        r_final <= w_sum;
                        r_fend  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                        r_acc <= w_sum;
                    end
                end
                S_DONE: begin
                    if (!bus.en_i) begin
                        r_state <= S_IDLE;
                        r_fend  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                    r_fend  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.idx_o   = r_idx;
    assign bus.final_o = r_final;
    assign bus.f_end_o = r_fend;
endmodule
